// File: rtl/lbcnn_fc_layer.sv
// lbcnn_fc_layer
//   Fully-connected output layer of the LBCNN classifier. One inference
//   computes NUM_OUT dot products of the captured feature vector against
//   weights streamed from an external memory. Each result gets a bias,
//   an arithmetic shift and 16-bit saturation. The layer also tracks the
//   arg-max class.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      launch one inference (sampled only while idle)
//   in_flat    FC_INPUT_SIZE x 16-bit signed features, element i at [16*i +: 16]
//   bias       NUM_OUT x 16-bit signed biases, held stable while busy
//   w_rd_en    weight memory read strobe
//   w_addr     weight address, n*FC_INPUT_SIZE + i
//   w_rdata    weight data, valid one cycle after w_rd_en
//   busy       inference in progress (through the done cycle)
//   done       one-cycle completion pulse
//   fc_out     NUM_OUT x 16-bit signed results, neuron n at [16*n +: 16]
//   class_idx  index of the largest fc_out (lowest index wins ties)
module lbcnn_fc_layer #(
   parameter  int FC_INPUT_SIZE = 49,
   parameter  int NUM_OUT       = 10,
   parameter  int SHIFT         = 0,
   parameter  int ACC_W         = 40,
   localparam int AW            = $clog2(FC_INPUT_SIZE * NUM_OUT),
   localparam int CW            = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic signed [FC_INPUT_SIZE*16-1:0] in_flat,
   input  logic signed [NUM_OUT*16-1:0]     bias,
   output logic                             w_rd_en,
   output logic [AW-1:0]                    w_addr,
   input  logic signed [15:0]               w_rdata,
   output logic                             busy,
   output logic                             done,
   output logic signed [NUM_OUT*16-1:0]     fc_out,
   output logic [CW-1:0]                    class_idx
);

   localparam int IW = (FC_INPUT_SIZE > 1) ? $clog2(FC_INPUT_SIZE + 1) : 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

   typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_t;

   state_t                   state_reg, state_next;
   logic [IW-1:0]            i_reg;
   logic [IW-1:0]            idx_d_reg;
   logic                     rd_vld_reg;
   logic [CW-1:0]            n_reg;
   logic [AW-1:0]            addr_reg;
   logic signed [ACC_W-1:0]  acc_reg;
   logic signed [15:0]       max_reg;
   logic [CW-1:0]            cls_reg;
   logic signed [15:0]       feat_reg [FC_INPUT_SIZE];

   logic signed [31:0]       prod;
   logic [15:0]              bias_sel;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [15:0]       sat_val;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (start) state_next = MAC;
         MAC:   if (i_reg == IW'(FC_INPUT_SIZE - 1)) state_next = DRAIN;
         DRAIN: state_next = WRITE;
         WRITE: state_next = (n_reg == CW'(NUM_OUT - 1)) ? DONE : MAC;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_rd_en = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;
      case (state_reg)
         IDLE: busy    = 1'b0;
         MAC:  w_rd_en = 1'b1;
         DONE: done    = 1'b1;
         default: ;
      endcase
   end

   // Snapshot of the features so upstream may change in_flat while busy.
   always_ff @(posedge clk) begin
      if (state_reg == IDLE && start) begin
         for (int k = 0; k < FC_INPUT_SIZE; k++)
            feat_reg[k] <= in_flat[k*16 +: 16];
      end
   end

   // Product uses the element index delayed to line up with w_rdata.
   assign prod     = 32'(feat_reg[idx_d_reg]) * 32'(w_rdata);
   assign bias_sel = bias[n_reg*16 +: 16];
   assign sum      = acc_reg + ACC_W'($signed(bias_sel));
   assign shifted  = sum >>> SHIFT;

   always_comb begin
      if (shifted > SAT_MAX)      sat_val = 16'sh7fff;
      else if (shifted < SAT_MIN) sat_val = 16'sh8000;
      else                        sat_val = shifted[15:0];
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_reg      <= '0;
         idx_d_reg  <= '0;
         rd_vld_reg <= 1'b0;
         n_reg      <= '0;
         addr_reg   <= '0;
         acc_reg    <= '0;
         max_reg    <= '0;
         cls_reg    <= '0;
      end else begin
         rd_vld_reg <= w_rd_en;
         idx_d_reg  <= i_reg;
         if (rd_vld_reg) acc_reg <= acc_reg + ACC_W'(prod);
         case (state_reg)
            IDLE: begin
               if (start) begin
                  i_reg    <= '0;
                  n_reg    <= '0;
                  addr_reg <= '0;
                  acc_reg  <= '0;
               end
            end
            MAC: begin
               i_reg    <= i_reg + IW'(1);
               // Address runs contiguously across neurons: after the last
               // element of neuron n it already equals (n+1)*FC_INPUT_SIZE.
               addr_reg <= addr_reg + AW'(1);
            end
            WRITE: begin
               acc_reg <= '0;
               i_reg   <= '0;
               if (n_reg != CW'(NUM_OUT - 1)) n_reg <= n_reg + CW'(1);
               // Strict greater-than keeps the lower index on ties.
               if (n_reg == '0 || sat_val > max_reg) begin
                  max_reg <= sat_val;
                  cls_reg <= n_reg;
               end
            end
            default: ;
         endcase
      end
   end

   // Per-neuron result registers, written only in WRITE for their index.
   generate
      for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
         logic signed [15:0] fc_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               fc_reg <= '0;
            else if (state_reg == WRITE && n_reg == CW'(gi))
               fc_reg <= sat_val;
         end
         assign fc_out[gi*16 +: 16] = fc_reg;
      end
   endgenerate

   assign w_addr    = addr_reg;
   assign class_idx = cls_reg;

endmodule

// File: tb/tb_lbcnn_fc_layer.sv
module tb_lbcnn_fc_layer;
   localparam int FC = 49;
   localparam int NO = 10;
   localparam int NW = FC * NO;
   localparam int LAT = NO * (FC + 2) + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic [FC*16-1:0] in_flat = '0;
   logic [NO*16-1:0] bias = '0;
   logic w_rd_en0, w_rd_en1;
   logic [8:0] w_addr0, w_addr1;
   logic [15:0] w_rdata0 = '0, w_rdata1 = '0;
   logic busy0, busy1, done0, done1;
   logic [NO*16-1:0] fc0, fc1;
   logic [3:0] cls0, cls1;

   int in_v[FC];
   int w_v[NW];
   int b_v[NO];
   int exp0[NO];
   int exp1[NO];
   int ecls0, ecls1;
   int n_checks = 0;
   int n_fail = 0;

   lbcnn_fc_layer #(.FC_INPUT_SIZE(FC), .NUM_OUT(NO), .SHIFT(0), .ACC_W(40)) dut0 (
      .clk(clk), .rst(rst), .start(start), .in_flat(in_flat), .bias(bias),
      .w_rd_en(w_rd_en0), .w_addr(w_addr0), .w_rdata(w_rdata0),
      .busy(busy0), .done(done0), .fc_out(fc0), .class_idx(cls0));

   lbcnn_fc_layer #(.FC_INPUT_SIZE(FC), .NUM_OUT(NO), .SHIFT(1), .ACC_W(40)) dut1 (
      .clk(clk), .rst(rst), .start(start), .in_flat(in_flat), .bias(bias),
      .w_rd_en(w_rd_en1), .w_addr(w_addr1), .w_rdata(w_rdata1),
      .busy(busy1), .done(done1), .fc_out(fc1), .class_idx(cls1));

   always #5 clk = ~clk;

   // Weight memories: data one cycle after the strobe, noise otherwise.
   always @(posedge clk) begin
      if (w_rd_en0 && int'(w_addr0) < NW) w_rdata0 <= 16'(w_v[w_addr0]);
      else                                w_rdata0 <= 16'($urandom);
      if (w_rd_en1 && int'(w_addr1) < NW) w_rdata1 <= 16'(w_v[w_addr1]);
      else                                w_rdata1 <= 16'($urandom);
   end

   function automatic int fcv(input logic [NO*16-1:0] v, input int n);
      logic [15:0] t;
      t = v[n*16 +: 16];
      return int'($signed(t));
   endfunction

   // Reference: plain dot product, bias, arithmetic shift, clamp.
   function automatic int neuron(input int n, input int shift);
      longint acc;
      acc = 0;
      for (int i = 0; i < FC; i++) acc += longint'(in_v[i]) * longint'(w_v[n*FC + i]);
      acc += longint'(b_v[n]);
      acc = acc >>> shift;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      return int'(acc);
   endfunction

   task automatic model_all();
      ecls0 = 0;
      ecls1 = 0;
      for (int n = 0; n < NO; n++) begin
         exp0[n] = neuron(n, 0);
         exp1[n] = neuron(n, 1);
         if (exp0[n] > exp0[ecls0]) ecls0 = n;
         if (exp1[n] > exp1[ecls1]) ecls1 = n;
      end
   endtask

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < FC; i++) in_flat[i*16 +: 16] = 16'(in_v[i]);
      for (int n = 0; n < NO; n++) bias[n*16 +: 16] = 16'(b_v[n]);
   endtask

   task automatic set_vector(input int inv, input int wb, input int ws, input int b3);
      for (int i = 0; i < FC; i++) in_v[i] = inv;
      for (int n = 0; n < NO; n++) begin
         b_v[n] = (n == 3) ? b3 : 0;
         for (int i = 0; i < FC; i++) w_v[n*FC + i] = wb + ws * n;
      end
   endtask

   // One inference; in_flat is scrambled right after acceptance, and
   // start may be re-pulsed at cycle pulse_at while busy.
   task automatic run_inf(input string tag, input int pulse_at);
      int d_cyc, d1_cyc, ndone, addr_exp, addr_err, rd_cnt, busy_cnt, idle_after;
      d_cyc = -1; d1_cyc = -1; ndone = 0; addr_exp = 0; addr_err = 0;
      rd_cnt = 0; busy_cnt = 0; idle_after = 0;
      model_all();
      apply_inputs();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < FC; k++) in_flat[k*16 +: 16] = 16'($urandom);
      for (int c = 1; c <= 1600; c++) begin
         @(negedge clk);
         start = (c == pulse_at);
         if (w_rd_en0) begin
            if (int'(w_addr0) != addr_exp) addr_err++;
            addr_exp++;
            rd_cnt++;
         end
         if (d_cyc >= 0 && c > d_cyc) begin
            if (busy0) idle_after++;
         end else if (busy0) busy_cnt++;
         if (done1 && d1_cyc < 0) d1_cyc = c;
         if (done0) begin
            ndone++;
            if (d_cyc < 0) d_cyc = c;
         end
         if (d_cyc >= 0 && c >= d_cyc + 5) break;
      end
      start = 1'b0;
      chk({tag, "_done_cycle"}, d_cyc, LAT);
      chk({tag, "_done1_cycle"}, d1_cyc, LAT);
      chk({tag, "_done_count"}, ndone, 1);
      chk({tag, "_addr_seq_err"}, addr_err, 0);
      chk({tag, "_rd_count"}, rd_cnt, NW);
      chk({tag, "_busy_cycles"}, busy_cnt, LAT);
      chk({tag, "_busy_after_done"}, idle_after, 0);
      for (int n = 0; n < NO; n++) begin
         chk($sformatf("%s_fc0[%0d]", tag, n), fcv(fc0, n), exp0[n]);
         chk($sformatf("%s_fc1[%0d]", tag, n), fcv(fc1, n), exp1[n]);
      end
      chk({tag, "_class0"}, int'(cls0), ecls0);
      chk({tag, "_class1"}, int'(cls1), ecls1);
      $display("run %s: done@%0d class0=%0d class1=%0d fc0[0]=%0d fc0[9]=%0d",
               tag, d_cyc, cls0, cls1, fcv(fc0, 0), fcv(fc0, 9));
   endtask

   typedef struct {
      string name;
      int    in_val;
      int    w_base;
      int    w_step;
      int    b3;
      int    pulse_at;
      int    exp_base;
      int    exp_step;
      int    exp_fc3;
      int    exp_cls;
   } vec_t;

   vec_t vecs[5];
   int dd1, dd2, cnt_done;

   initial begin
      vecs[0] = '{"ones",      1,     1,    0,   0,   0,     49,  0,     49, 0};
      vecs[1] = '{"ramp",      1,     0,    1,   0, 100,      0, 49,    147, 9};
      vecs[2] = '{"sat_pos", 1000,  1000,    0,   0,   0,  32767,  0,  32767, 0};
      vecs[3] = '{"sat_neg", 1000, -1000,    0,   0,   0, -32768,  0, -32768, 0};
      vecs[4] = '{"bias3",     2,     1,    0, 100,   0,     98,  0,    198, 3};

      // Reset state
      #1;
      chk("rst_busy", int'(busy0), 0);
      chk("rst_done", int'(done0), 0);
      chk("rst_w_rd_en", int'(w_rd_en0), 0);
      chk("rst_w_addr", int'(w_addr0), 0);
      chk("rst_fc_out_nonzero", int'(fc0 != '0), 0);
      chk("rst_class", int'(cls0), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Directed table
      for (int v = 0; v < 5; v++) begin
         set_vector(vecs[v].in_val, vecs[v].w_base, vecs[v].w_step, vecs[v].b3);
         run_inf(vecs[v].name, vecs[v].pulse_at);
         for (int n = 0; n < NO; n++)
            chk($sformatf("%s_table_fc[%0d]", vecs[v].name, n), fcv(fc0, n),
                (n == 3) ? vecs[v].exp_fc3 : vecs[v].exp_base + vecs[v].exp_step * n);
         chk({vecs[v].name, "_table_class"}, int'(cls0), vecs[v].exp_cls);
      end

      // SHIFT=1 instance after the bias3 vector: 198>>>1=99, 98>>>1=49
      for (int n = 0; n < NO; n++)
         chk($sformatf("shift1_fc[%0d]", n), fcv(fc1, n), (n == 3) ? 99 : 49);
      chk("shift1_class", int'(cls1), 3);

      // Randomized runs against the reference model
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < FC; i++) in_v[i] = int'($urandom_range(0, 200)) - 100;
         for (int k = 0; k < NW; k++) w_v[k] = int'($urandom_range(0, 40 + 400 * r)) - (20 + 200 * r);
         for (int n = 0; n < NO; n++) b_v[n] = int'($urandom_range(0, 65535)) - 32768;
         run_inf($sformatf("rand%0d", r), (r == 1) ? 300 : 0);
      end

      // start held high: back-to-back inferences
      set_vector(1, 1, 0, 0);
      apply_inputs();
      dd1 = -1; dd2 = -1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 1200; c++) begin
         @(negedge clk);
         if (done0) begin
            if (dd1 < 0) dd1 = c;
            else if (dd2 < 0) dd2 = c;
         end
         if (dd2 >= 0) break;
      end
      start = 1'b0;
      chk("held_start_done1", dd1, LAT);
      chk("held_start_done2", dd2, 2 * LAT + 1);
      for (int c = 0; c < 600 && busy0; c++) @(negedge clk);
      chk("held_start_idle", int'(busy0), 0);
      $display("run held_start: done@%0d and @%0d", dd1, dd2);

      // Reset during MAC of neuron 4, then a fresh run
      set_vector(1, 1, 0, 0);
      apply_inputs();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (213) @(negedge clk);
      chk("pre_rst_in_mac", int'(w_rd_en0), 1);
      rst = 1'b0;
      #1;
      chk("abort_busy", int'(busy0), 0);
      chk("abort_done", int'(done0), 0);
      chk("abort_w_rd_en", int'(w_rd_en0), 0);
      chk("abort_w_addr", int'(w_addr0), 0);
      chk("abort_fc_out_nonzero", int'(fc0 != '0), 0);
      chk("abort_class", int'(cls0), 0);
      cnt_done = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (c == 4) rst = 1'b1;
         if (done0 || busy0) cnt_done++;
      end
      chk("abort_no_activity", cnt_done, 0);
      $display("run abort: reset asserted in neuron 4 MAC");
      run_inf("after_reset", 0);
      for (int n = 0; n < NO; n++)
         chk($sformatf("after_reset_table_fc[%0d]", n), fcv(fc0, n), 49);
      chk("after_reset_table_class", int'(cls0), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/lbcnn_fc_layer.md
LBCNN_FC_LAYER -- requirements
Module: lbcnn_fc_layer

Interface
REQ-001 Parameter: FC_INPUT_SIZE, 49, length of the flattened feature vector from the LBCNN feature stage.
REQ-002 Parameter: NUM_OUT, 10, number of output neurons (classes).
REQ-003 Parameter: SHIFT, 0, arithmetic right-shift applied to accumulator before saturation.
REQ-004 Parameter: ACC_W, 40, accumulator width in bits, signed.
REQ-005 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port: rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 Port: start  input  1  request one inference; sampled only in IDLE.
REQ-008 Port: in_flat  input  FC_INPUT_SIZE x 16 signed  flattened feature vector (output_flat of upstream stage).
REQ-009 Port: bias  input  NUM_OUT x 16 signed  per-neuron bias, held stable while busy.
REQ-010 Port: w_rd_en  output  1  weight memory read strobe.
REQ-011 Port: w_addr  output  clog2(FC_INPUT_SIZE*NUM_OUT)  weight address = n*FC_INPUT_SIZE + i.
REQ-012 Port: w_rdata  input  16 signed  weight data, valid exactly 1 cycle after w_rd_en.
REQ-013 Port: busy  output  1  high from cycle after start accepted until done cycle inclusive.
REQ-014 Port: done  output  1  single-cycle pulse, results valid.
REQ-015 Port: fc_out  output  NUM_OUT x 16 signed  neuron outputs, held until next start accepted.
REQ-016 Port: class_idx  output  clog2(NUM_OUT)  index of maximum fc_out, valid when done and held.

Function
REQ-017 FSM states SHALL be IDLE, MAC, DRAIN, WRITE, DONE.
REQ-018 IDLE: start=1 -> in_flat copied into internal buffer, neuron n=0, element i=0, accumulator cleared, go MAC; in_flat changes afterwards SHALL not affect the result.
REQ-019 MAC: each cycle w_rd_en=1, w_addr=n*FC_INPUT_SIZE+i, i increments; after i=FC_INPUT_SIZE-1 go DRAIN.
REQ-020 Each cycle with valid w_rdata, accumulator += buffer[i_delayed]*w_rdata (32-bit signed product, sign-extended to ACC_W).
REQ-021 DRAIN: w_rd_en=0; last product accumulated; go WRITE.
REQ-022 WRITE: value = (acc + sign-extended bias[n]) >>> SHIFT; saturate to [-32768, 32767]; store to fc_out[n]; accumulator cleared.
REQ-023 WRITE: if n==0 or value > running max, running max=value and class_idx=n; ties keep lower index.
REQ-024 WRITE: n<NUM_OUT-1 -> n++, i=0, go MAC; else go DONE.
REQ-025 DONE: done=1 for exactly one cycle, busy=1, go IDLE.
REQ-026 Latency: done SHALL be high in cycle NUM_OUT*(FC_INPUT_SIZE+2)+1 counting the start-sampling edge as cycle 0 (511 for defaults).
REQ-027 start while not IDLE SHALL be ignored and not queued.
REQ-028 start held high continuously SHALL launch a new inference on the cycle after each DONE.
REQ-029 w_rd_en SHALL be low in every state except MAC.
REQ-030 fc_out entries SHALL update only in WRITE; unwritten entries hold previous-inference values until overwritten.

Reset
REQ-031 rst=0 SHALL immediately force: state IDLE, busy=0, done=0, w_rd_en=0, w_addr=0, fc_out all 0, class_idx=0, accumulator 0, counters 0.
REQ-032 Reset during MAC/DRAIN/WRITE SHALL abort the inference with no done pulse; first start after rst=1 runs a full fresh inference.

Verification
REQ-033 in_flat all 1, all weights 1, bias 0 -> every fc_out=49, class_idx=0 (tie rule), done at cycle 511.
REQ-034 weights of neuron n all = n, in_flat all 1, bias 0 -> fc_out[n]=49*n, class_idx=9.
REQ-035 in_flat all 1000, weights all 1000 -> fc_out=32767; weights all -1000 -> fc_out=-32768.
REQ-036 in_flat all 2, weights 1, bias[3]=100, SHIFT=1 build -> fc_out[3]=99, others 49, class_idx=3.
REQ-037 start pulsed at cycle 100 of an inference -> ignored, single done at 511, w_addr sequence 0..489 uninterrupted.
REQ-038 rst=0 during MAC of neuron 4 -> all outputs 0 same cycle, no done; restart -> correct results of REQ-033.
